// File: rtl/spi_slave_sync.sv
// SPI mode-0 slave oversampled on clk: pin synchronizers, edge strobes, byte shift FSM.
// Optional macro SPI_SLAVE_MISO_TRISTATE_EN floats miso outside the ACTIVE state.
module spi_slave_sync #(
  parameter int SYNC_STAGES = 2  // 2 or 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       ss_l,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  // state  | meaning
  // IDLE   | deselected, sclk edges ignored
  // ACTIVE | selected, shifting bits on sclk edges
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_d, ss_d;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;

  logic [7:0] rx_sr, tx_sr;
  logic [2:0] bit_cnt;

  logic load_tx, shift_rx, shift_tx, clr_cnt, byte_done;

  // Synchronizers are left unreset so a reset mid-select cannot fake an ss_l edge.
  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
    ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_l};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    sclk_d    <= sclk_s;
    ss_d      <= ss_s;
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_fall   = ~ss_s & ss_d;
  assign ss_rise   = ss_s & ~ss_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_tx   = 1'b0;
    shift_rx  = 1'b0;
    shift_tx  = 1'b0;
    clr_cnt   = 1'b0;
    byte_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = ACTIVE;
          load_tx = 1'b1;
          clr_cnt = 1'b1;
        end
      end
      ACTIVE: begin
        if (sclk_rise) begin
          shift_rx  = 1'b1;
          byte_done = (bit_cnt == 3'd7);
        end
        // A zero count on a falling edge means the previous rise closed a byte.
        if (sclk_fall) begin
          if (bit_cnt == 3'd0) load_tx  = 1'b1;
          else                 shift_tx = 1'b1;
        end
        if (ss_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sr    <= 8'h00;
      tx_sr    <= 8'h00;
      bit_cnt  <= 3'd0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
    end else begin
      rx_valid <= byte_done;
      tx_load  <= load_tx;
      if (byte_done) rx_data <= {rx_sr[6:0], mosi_s};
      if (shift_rx) begin
        rx_sr   <= {rx_sr[6:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
      end else if (clr_cnt) begin
        bit_cnt <= 3'd0;
      end
      if (load_tx)       tx_sr <= tx_data;
      else if (shift_tx) tx_sr <= {tx_sr[6:0], 1'b0};
    end
  end

  assign busy = (state_q == ACTIVE);

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign miso = (state_q == ACTIVE && !rst) ? tx_sr[7] : 1'bz;
`else
  assign miso = (state_q == ACTIVE && !rst) ? tx_sr[7] : 1'b0;
`endif

endmodule
